// File: rtl/alu_sequencer.sv
// ============================================================================
// Module   : alu_sequencer
// Brief    : Board-level sequencing controller for the N-bit lab ALU.
//            Collects operands and a command from switches/pushbuttons,
//            drives the ALU control inputs for a settle window, and captures
//            result and flags into hold registers for the display stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer #(
   parameter int N      = 4,
   parameter int SETTLE = 1    // EXEC cycles before capture, 1..15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] sw_data,
   input  logic [3:0]   sw_cmd,
   input  logic         btn_load_a,
   input  logic         btn_load_b,
   input  logic         btn_exec,
   input  logic         btn_clear,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [2:0]   alu_op,
   output logic         alu_op_sum,
   output logic         alu_op_subt,
   input  logic [N-1:0] alu_result,
   input  logic [N-1:0] alu_multi_hi,
   input  logic [3:0]   alu_flags,
   output logic [N-1:0] res_q,
   output logic [N-1:0] res_hi_q,
   output logic [3:0]   flags_q,
   output logic         res_valid,
   output logic         busy,
   output logic         err_cmd,
   output logic         err_div0,
   output logic [2:0]   state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HAVE_A = 3'd1,
      S_HAVE_B = 3'd2,
      S_EXEC   = 3'd3,
      S_DONE   = 3'd4,
      S_ERROR  = 3'd5
   } state_t;

   // Counter reloads with SETTLE-1 so capture lands on the SETTLE-th EXEC cycle.
   localparam logic [3:0] C_SETTLE_M1 = 4'(SETTLE - 1);
   localparam logic [3:0] C_CMD_MOD   = 4'd3;
   localparam logic [3:0] C_CMD_DIV   = 4'd4;
   localparam logic [3:0] C_CMD_MUL   = 4'd5;
   localparam logic [3:0] C_CMD_ADD   = 4'd8;
   localparam logic [3:0] C_CMD_SUB   = 4'd9;
   localparam logic [3:0] C_CMD_LAST  = 4'd9;

   state_t       r_state;
   state_t       w_next;

   logic [3:0]   r_btn_prev;   // {clear, exec, load_b, load_a}
   logic [N-1:0] r_a;
   logic [N-1:0] r_b;
   logic [3:0]   r_cmd;
   logic [N-1:0] r_res;
   logic [N-1:0] r_res_hi;
   logic [3:0]   r_flags;
   logic         r_valid;
   logic         r_err_cmd;
   logic         r_err_div0;
   logic [3:0]   r_cnt;

   logic         w_p_a;
   logic         w_p_b;
   logic         w_p_exec;
   logic         w_p_clr;
   logic         w_cmd_illegal;
   logic         w_div0;

   logic         w_ld_a;
   logic         w_ld_b;
   logic         w_ld_cmd;
   logic         w_start;
   logic         w_cnt_dec;
   logic         w_capture;
   logic         w_clr_valid;
   logic         w_set_err_cmd;
   logic         w_set_err_div0;

   // Rising-edge pulses with clear > load_a > load_b > exec priority: a
   // lower-priority pulse is dropped whenever a higher one fires.
   assign w_p_clr  = btn_clear  & ~r_btn_prev[3];
   assign w_p_a    = btn_load_a & ~r_btn_prev[0] & ~w_p_clr;
   assign w_p_b    = btn_load_b & ~r_btn_prev[1] & ~w_p_clr & ~w_p_a;
   assign w_p_exec = btn_exec   & ~r_btn_prev[2] & ~w_p_clr & ~w_p_a & ~w_p_b;

   // The command being accepted comes straight from the switches.
   assign w_cmd_illegal = (sw_cmd > C_CMD_LAST);
   assign w_div0        = ((sw_cmd == C_CMD_MOD) || (sw_cmd == C_CMD_DIV)) &&
                          (r_b == '0);

   // Button history; reset high so a button held through reset is not a press.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_btn_prev <= 4'b1111;
      end else begin
         r_btn_prev <= {btn_clear, btn_exec, btn_load_b, btn_load_a};
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and datapath strobes.
   always_comb begin
      w_next         = r_state;
      w_ld_a         = 1'b0;
      w_ld_b         = 1'b0;
      w_ld_cmd       = 1'b0;
      w_start        = 1'b0;
      w_cnt_dec      = 1'b0;
      w_capture      = 1'b0;
      w_clr_valid    = 1'b0;
      w_set_err_cmd  = 1'b0;
      w_set_err_div0 = 1'b0;
      if (w_p_clr) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_p_a) begin
                  w_ld_a = 1'b1;
                  w_next = S_HAVE_A;
               end
            end
            S_HAVE_A: begin
               if (w_p_a) begin
                  w_ld_a = 1'b1;
               end else if (w_p_b) begin
                  w_ld_b = 1'b1;
                  w_next = S_HAVE_B;
               end
            end
            S_HAVE_B: begin
               if (w_p_a) begin
                  w_ld_a = 1'b1;
               end else if (w_p_b) begin
                  w_ld_b = 1'b1;
               end else if (w_p_exec) begin
                  w_ld_cmd    = 1'b1;
                  w_clr_valid = 1'b1;
                  if (w_cmd_illegal) begin
                     w_set_err_cmd = 1'b1;
                     w_next        = S_ERROR;
                  end else if (w_div0) begin
                     w_set_err_div0 = 1'b1;
                     w_next         = S_ERROR;
                  end else begin
                     w_start = 1'b1;
                     w_next  = S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               if (r_cnt == 4'd0) begin
                  w_capture = 1'b1;
                  w_next    = S_DONE;
               end else begin
                  w_cnt_dec = 1'b1;
               end
            end
            S_DONE: begin
               if (w_p_a) begin
                  w_ld_a      = 1'b1;
                  w_clr_valid = 1'b1;
                  w_next      = S_HAVE_A;
               end
            end
            S_ERROR: begin
               w_next = S_ERROR;
            end
            default: begin
               w_next = S_IDLE;
            end
         endcase
      end
   end

   // Operand, command, settle counter, capture and error registers.
   always_ff @(posedge clk) begin
      if (rst || w_p_clr) begin
         r_a        <= '0;
         r_b        <= '0;
         r_cmd      <= '0;
         r_res      <= '0;
         r_res_hi   <= '0;
         r_flags    <= '0;
         r_valid    <= 1'b0;
         r_err_cmd  <= 1'b0;
         r_err_div0 <= 1'b0;
         r_cnt      <= '0;
      end else begin
         if (w_ld_a) begin
            r_a <= sw_data;
         end
         if (w_ld_b) begin
            r_b <= sw_data;
         end
         if (w_ld_cmd) begin
            r_cmd <= sw_cmd;
         end
         if (w_start) begin
            r_cnt <= C_SETTLE_M1;
         end else if (w_cnt_dec) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_capture) begin
            r_res    <= alu_result;
            r_flags  <= alu_flags;
            r_res_hi <= (r_cmd == C_CMD_MUL) ? alu_multi_hi : '0;
            r_valid  <= 1'b1;
         end else if (w_clr_valid) begin
            r_valid <= 1'b0;
         end
         if (w_set_err_cmd) begin
            r_err_cmd <= 1'b1;
         end
         if (w_set_err_div0) begin
            r_err_div0 <= 1'b1;
         end
      end
   end

   // ALU drive: add/subtract enables only while executing.
   assign alu_a       = r_a;
   assign alu_b       = r_b;
   assign alu_op      = r_cmd[2:0];
   assign alu_op_sum  = (r_state == S_EXEC) && (r_cmd == C_CMD_ADD);
   assign alu_op_subt = (r_state == S_EXEC) && (r_cmd == C_CMD_SUB);

   assign res_q     = r_res;
   assign res_hi_q  = r_res_hi;
   assign flags_q   = r_flags;
   assign res_valid = r_valid;
   assign busy      = (r_state == S_EXEC);
   assign err_cmd   = r_err_cmd;
   assign err_div0  = r_err_div0;
   assign state_o   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Self-checking bench for alu_sequencer (SETTLE=1 and SETTLE=3
//            instances sharing board stimulus, each with its own ALU model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sw_data;
   logic [3:0] sw_cmd;
   logic       btn_load_a, btn_load_b, btn_exec, btn_clear;

   logic [3:0] alu_a1, alu_b1, alu_res1, alu_hi1, alu_flags1;
   logic [3:0] res_q1, res_hi_q1, flags_q1;
   logic [2:0] alu_op1, state1;
   logic       sum1, subt1, valid1, busy1, ec1, ed1;

   logic [3:0] alu_a3, alu_b3, alu_res3, alu_hi3, alu_flags3;
   logic [3:0] res_q3, res_hi_q3, flags_q3;
   logic [2:0] alu_op3, state3;
   logic       sum3, subt3, valid3, busy3, ec3, ed3;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_sequencer #(.N(4), .SETTLE(1)) u_dut1 (
      .clk(clk), .rst(rst), .sw_data(sw_data), .sw_cmd(sw_cmd),
      .btn_load_a(btn_load_a), .btn_load_b(btn_load_b),
      .btn_exec(btn_exec), .btn_clear(btn_clear),
      .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1),
      .alu_op_sum(sum1), .alu_op_subt(subt1),
      .alu_result(alu_res1), .alu_multi_hi(alu_hi1), .alu_flags(alu_flags1),
      .res_q(res_q1), .res_hi_q(res_hi_q1), .flags_q(flags_q1),
      .res_valid(valid1), .busy(busy1), .err_cmd(ec1), .err_div0(ed1),
      .state_o(state1)
   );

   alu_sequencer #(.N(4), .SETTLE(3)) u_dut3 (
      .clk(clk), .rst(rst), .sw_data(sw_data), .sw_cmd(sw_cmd),
      .btn_load_a(btn_load_a), .btn_load_b(btn_load_b),
      .btn_exec(btn_exec), .btn_clear(btn_clear),
      .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
      .alu_op_sum(sum3), .alu_op_subt(subt3),
      .alu_result(alu_res3), .alu_multi_hi(alu_hi3), .alu_flags(alu_flags3),
      .res_q(res_q3), .res_hi_q(res_hi_q3), .flags_q(flags_q3),
      .res_valid(valid3), .busy(busy3), .err_cmd(ec3), .err_div0(ed3),
      .state_o(state3)
   );

   // Lab ALU stand-in: returns {product_hi, result, {neg, zero, carry, over}}.
   function automatic logic [11:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op, input logic s,
                                         input logic d);
      logic [7:0] p;
      logic [4:0] t;
      logic [3:0] r;
      logic       c, v;
      p = 8'(a) * 8'(b);
      c = 1'b0;
      v = 1'b0;
      r = 4'd0;
      if (s) begin
         t = {1'b0, a} + {1'b0, b};
         r = t[3:0];
         c = t[4];
         v = (a[3] == b[3]) && (r[3] != a[3]);
      end else if (d) begin
         t = {1'b0, a} + {1'b0, ~b} + 5'd1;
         r = t[3:0];
         c = t[4];
         v = (a[3] != b[3]) && (r[3] != a[3]);
      end else begin
         case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = (b == 4'd0) ? 4'd0 : a % b;
            3'd4: r = (b == 4'd0) ? 4'd0 : a / b;
            3'd5: r = p[3:0];
            3'd6: r = a >> b;
            default: r = a << b;
         endcase
      end
      return {p[7:4], r, r[3], (r == 4'd0), c, v};
   endfunction

   always_comb {alu_hi1, alu_res1, alu_flags1} = alu_f(alu_a1, alu_b1, alu_op1, sum1, subt1);
   always_comb {alu_hi3, alu_res3, alu_flags3} = alu_f(alu_a3, alu_b3, alu_op3, sum3, subt3);

   typedef struct {
      logic [3:0] a, b, cmd;
      logic [2:0] st;
      logic       v, ec, ed;
      logic [3:0] res, hi, fl;
   } vec_t;

   vec_t vecs[15];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_clear();
      btn_clear = 1'b1; tick(); btn_clear = 1'b0; tick();
   endtask

   task automatic do_load_a(input logic [3:0] v);
      sw_data = v; btn_load_a = 1'b1; tick(); btn_load_a = 1'b0; tick();
   endtask

   task automatic do_load_b(input logic [3:0] v);
      sw_data = v; btn_load_b = 1'b1; tick(); btn_load_b = 1'b0; tick();
   endtask

   task automatic do_exec(input logic [3:0] c);
      sw_cmd = c; btn_exec = 1'b1; tick(); btn_exec = 1'b0; tick();
   endtask

   function automatic logic [31:0] all1();
      return {alu_a1, alu_b1, alu_op1, sum1, subt1, res_q1, res_hi_q1,
              flags_q1, valid1, busy1, ec1, ed1, state1};
   endfunction

   initial begin
      logic       saw_busy;
      logic [3:0] fl_k1;

      //            a      b      cmd    st    v     ec    ed    res    hi     fl
      vecs[0]  = '{4'd5,  4'd3,  4'd8,  3'd4, 1'b1, 1'b0, 1'b0, 4'h8, 4'h0, 4'h9};
      vecs[1]  = '{4'd7,  4'd6,  4'd5,  3'd4, 1'b1, 1'b0, 1'b0, 4'hA, 4'h2, 4'h8};
      vecs[2]  = '{4'd3,  4'd5,  4'd9,  3'd4, 1'b1, 1'b0, 1'b0, 4'hE, 4'h0, 4'h8};
      vecs[3]  = '{4'd12, 4'd5,  4'd0,  3'd4, 1'b1, 1'b0, 1'b0, 4'h4, 4'h0, 4'h0};
      vecs[4]  = '{4'd12, 4'd5,  4'd1,  3'd4, 1'b1, 1'b0, 1'b0, 4'hD, 4'h0, 4'h8};
      vecs[5]  = '{4'd12, 4'd5,  4'd2,  3'd4, 1'b1, 1'b0, 1'b0, 4'h9, 4'h0, 4'h8};
      vecs[6]  = '{4'd13, 4'd4,  4'd3,  3'd4, 1'b1, 1'b0, 1'b0, 4'h1, 4'h0, 4'h0};
      vecs[7]  = '{4'd13, 4'd4,  4'd4,  3'd4, 1'b1, 1'b0, 1'b0, 4'h3, 4'h0, 4'h0};
      vecs[8]  = '{4'd9,  4'd1,  4'd6,  3'd4, 1'b1, 1'b0, 1'b0, 4'h4, 4'h0, 4'h0};
      vecs[9]  = '{4'd3,  4'd2,  4'd7,  3'd4, 1'b1, 1'b0, 1'b0, 4'hC, 4'h0, 4'h8};
      vecs[10] = '{4'd9,  4'd0,  4'd4,  3'd5, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0};
      vecs[11] = '{4'd4,  4'd0,  4'd3,  3'd5, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0};
      vecs[12] = '{4'd1,  4'd2,  4'd12, 3'd5, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
      vecs[13] = '{4'd8,  4'd8,  4'd8,  3'd4, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h7};
      vecs[14] = '{4'd0,  4'd5,  4'd9,  3'd4, 1'b1, 1'b0, 1'b0, 4'hB, 4'h0, 4'h8};

      rst = 1'b1; sw_data = 4'd0; sw_cmd = 4'd0;
      btn_load_a = 1'b0; btn_load_b = 1'b0; btn_exec = 1'b0; btn_clear = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("reset_state", all1(), 32'd0);

      // Table: full load/exec per vector, checked once both instances are done.
      for (int i = 0; i < 15; i++) begin
         do_clear();
         do_load_a(vecs[i].a);
         do_load_b(vecs[i].b);
         do_exec(vecs[i].cmd);
         tick(); tick();
         chk($sformatf("vec%0d_s1", i),
             {state1, valid1, ec1, ed1, res_q1, res_hi_q1, flags_q1},
             {vecs[i].st, vecs[i].v, vecs[i].ec, vecs[i].ed, vecs[i].res, vecs[i].hi, vecs[i].fl});
         chk($sformatf("vec%0d_s3", i),
             {state3, valid3, ec3, ed3, res_q3, res_hi_q3, flags_q3},
             {vecs[i].st, vecs[i].v, vecs[i].ec, vecs[i].ed, vecs[i].res, vecs[i].hi, vecs[i].fl});
      end

      // Add latency: sum enable only in k+1, capture visible at k+2.
      do_clear(); do_load_a(4'd5); do_load_b(4'd3);
      sw_cmd = 4'd8; btn_exec = 1'b1;
      chk("add_pre_k", {state1, sum1, subt1, busy1}, {3'd2, 1'b0, 1'b0, 1'b0});
      tick();
      btn_exec = 1'b0;
      fl_k1 = alu_flags1;
      chk("add_k1", {state1, sum1, subt1, busy1, valid1}, {3'd3, 1'b1, 1'b0, 1'b1, 1'b0});
      chk("add_k1_flags", fl_k1, 4'h9);
      tick();
      chk("add_k2", {state1, sum1, busy1, valid1, res_q1, res_hi_q1}, {3'd4, 1'b0, 1'b0, 1'b1, 4'd8, 4'd0});
      chk("add_k2_flags", flags_q1, fl_k1);

      // Multiply: add/subtract enables stay low through execution.
      do_clear(); do_load_a(4'd7); do_load_b(4'd6);
      sw_cmd = 4'd5; btn_exec = 1'b1; tick(); btn_exec = 1'b0;
      chk("mul_exec", {state1, sum1, subt1}, {3'd3, 1'b0, 1'b0});
      tick();
      chk("mul_done", {sum1, subt1, valid1, res_q1, res_hi_q1}, {1'b0, 1'b0, 1'b1, 4'hA, 4'h2});

      // Divide by zero: never busy; clear returns everything to zero.
      do_clear(); do_load_a(4'd9); do_load_b(4'd0);
      sw_cmd = 4'd4; btn_exec = 1'b1; saw_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         btn_exec = 1'b0;
         saw_busy = saw_busy | busy1 | busy3;
      end
      chk("div0_nobusy", saw_busy, 1'b0);
      chk("div0_err", {ed1, ec1, state1, valid1}, {1'b1, 1'b0, 3'd5, 1'b0});
      do_clear();
      chk("div0_clear", all1(), 32'd0);

      // Illegal command: ERROR is sticky against load/exec pulses.
      do_load_a(4'd1); do_load_b(4'd2); do_exec(4'd12);
      chk("ill_err", {ec1, ed1, state1}, {1'b1, 1'b0, 3'd5});
      do_load_a(4'd7); do_load_b(4'd7); do_exec(4'd8);
      chk("ill_sticky", {ec1, state1, valid1, busy1, alu_a1, alu_b1},
          {1'b1, 3'd5, 1'b0, 1'b0, 4'd1, 4'd2});
      do_clear();

      // SETTLE=3: clear in the second EXEC cycle aborts with no capture.
      do_load_a(4'd5); do_load_b(4'd3);
      sw_cmd = 4'd8; btn_exec = 1'b1; tick(); btn_exec = 1'b0;
      tick();
      chk("abort_exec2", {state3, busy3}, {3'd3, 1'b1});
      btn_clear = 1'b1; tick(); btn_clear = 1'b0;
      chk("abort_idle", {state3, valid3, res_q3}, {3'd0, 1'b0, 4'd0});
      tick(); tick(); tick();
      chk("abort_stays", {state3, valid3, res_q3}, {3'd0, 1'b0, 4'd0});

      // load_a and exec rising together in HAVE_B: only A reloads.
      do_load_a(4'd2); do_load_b(4'd3);
      sw_data = 4'd9; sw_cmd = 4'd8; btn_load_a = 1'b1; btn_exec = 1'b1;
      tick();
      chk("prio_same", {state1, alu_a1, alu_b1, busy1, state3}, {3'd2, 4'd9, 4'd3, 1'b0, 3'd2});
      btn_load_a = 1'b0; btn_exec = 1'b0;
      tick();
      chk("prio_after", {state1, busy1}, {3'd2, 1'b0});

      // Reset while in DONE zeroes every output.
      do_exec(4'd8);
      chk("pre_rst_done", {state1, valid1}, {3'd4, 1'b1});
      rst = 1'b1; tick();
      chk("rst_in_done", all1(), 32'd0);

      // Buttons held through reset release produce no pulse.
      sw_data = 4'd6; btn_exec = 1'b1; btn_load_a = 1'b1;
      tick();
      rst = 1'b0;
      tick(); tick();
      chk("held_btn_rst", {state1, alu_a1, state3, alu_a3}, {3'd0, 4'd0, 3'd0, 4'd0});
      btn_exec = 1'b0; btn_load_a = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Sequencing controller for the N-bit lab ALU (add, subtract, divide, modulo, multiply, bitwise logic, shifts).
- Collects operand A, operand B and a command from board switches and pushbuttons, drives the ALU control inputs for a fixed settle window, and captures result and flags into hold registers for the 7-segment and LED stage.
- Rejects illegal commands and division/modulo by zero.

Parameters:
- N, 4, operand/result width; matches the ALU N.
- SETTLE, 1, EXEC cycles before capture; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sw_data  in  N  operand switches
- sw_cmd  in  4  command switches
- btn_load_a  in  1  level; its rising edge loads A
- btn_load_b  in  1  level; its rising edge loads B
- btn_exec  in  1  level; its rising edge starts execution
- btn_clear  in  1  level; its rising edge aborts and clears
- alu_a  out  N  ALU operand a (= a_q)
- alu_b  out  N  ALU operand b (= b_q)
- alu_op  out  3  ALU op select
- alu_op_sum  out  1  ALU add enable
- alu_op_subt  out  1  ALU subtract enable
- alu_result  in  N  ALU result
- alu_multi_hi  in  N  multiply product bits [2N-1:N]
- alu_flags  in  4  {neg, zero, carry, over} from ALU
- res_q  out  N  captured result
- res_hi_q  out  N  captured product high half
- flags_q  out  4  captured flags
- res_valid  out  1  capture registers hold a valid result
- busy  out  1  high in EXEC
- err_cmd  out  1  illegal command latched
- err_div0  out  1  divide/modulo by zero latched
- state_o  out  3  current state encoding, for debug LEDs

Behaviour:
- Edge detect: prev register per button; pulse = btn & ~prev. Prev registers reset to 1, so a button held through reset gives no pulse.
- Priority for simultaneous pulses: clear > load_a > load_b > exec.
- Command map, sw_cmd to ALU controls:
  - 0..7: alu_op = sw_cmd[2:0]; 0 and, 1 or, 2 xor, 3 modulo, 4 divide, 5 multiply, 6 shift right, 7 shift left.
  - 8: add. 9: subtract.
  - 10..15: illegal.
- cmd_q is latched on the accepted exec pulse.
- alu_op always reflects cmd_q[2:0].
- alu_op_sum / alu_op_subt are asserted only in EXEC and only for cmd 8 / 9; at most one is high; both 0 elsewhere.
- States and encodings:
  - IDLE 0: load_a loads a_q from sw_data, goes to HAVE_A. Other pulses are ignored.
  - HAVE_A 1: load_a reloads a_q. load_b loads b_q, goes to HAVE_B. exec is ignored.
  - HAVE_B 2: load_a / load_b reload the respective register. exec handling:
    - cmd illegal: set err_cmd, go to ERROR.
    - cmd 3 or 4 with b_q == 0: set err_div0, go to ERROR.
    - otherwise: clear res_valid, load settle counter, go to EXEC.
  - EXEC 3: busy=1; all pulses except clear are ignored. On the SETTLE-th cycle:
    - capture res_q <= alu_result and flags_q <= alu_flags;
    - res_hi_q <= alu_multi_hi for cmd 5, else 0;
    - set res_valid, go to DONE.
  - DONE 4: outputs held. load_a loads a_q, clears res_valid, goes to HAVE_A. load_b and exec are ignored.
  - ERROR 5: error flag held, res_valid=0. Only clear exits.
  - clear pulse in any state: go to IDLE; zero a_q, b_q, cmd_q, res_q, res_hi_q, flags_q, res_valid, err_cmd, err_div0. Clear during EXEC aborts with no capture.
- Latency: exec pulse in cycle k → EXEC in cycles k+1..k+SETTLE → res_valid=1 from cycle k+SETTLE+1.
- Reset: state IDLE; all registers and outputs 0 except button prev regs (reset to 1). rst has priority over every pulse.
- Undefined state encodings return to IDLE on the next cycle.

Test Plan:
- N=4, SETTLE=1: load_a 5, load_b 3, cmd 8, exec in cycle k → alu_op_sum=1 only in k+1; res_q=8, res_hi_q=0, res_valid=1 at k+2; flags_q equals alu_flags sampled in k+1.
- A=7, B=6, cmd 5 → res_q=0xA, res_hi_q=0x2, res_valid=1; alu_op_sum=alu_op_subt=0 throughout.
- A=9, B=0, cmd 4 → err_div0=1, state_o=5, res_valid=0, busy never high. Then clear → all zero, state_o=0.
- cmd 12 with exec in HAVE_B → err_cmd=1, ERROR state. Load/exec pulses change nothing until clear.
- SETTLE=3: clear in second EXEC cycle → IDLE next cycle, res_valid stays 0, res_q unchanged at 0. Also check load_a and exec rising in the same cycle from HAVE_B → only a_q reloads, state stays HAVE_B.
- btn_exec held high through rst release → no pulse, state IDLE. Asserting rst in DONE → all outputs 0 next cycle.
